// File: rtl/uart_rx_os.sv
// UART receiver with 16x oversampling, 2-of-3 majority bit decisions, parity/stop
// checking, break detection and a first-word-fall-through receive FIFO.
module uart_rx_os #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          serial_rx,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          break_det,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int TW  = $clog2(DIV + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [3:0]           hi_cnt_q, hi_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 s7_q, s7_d;
  logic                 s8_q, s8_d;
  logic                 push_q, push_d;
  logic                 break_q, break_d;

  logic rx_s, tick, maj, decide, stop_ferr, exp_par;

  assign rx_s      = sync_q[1];
  assign tick      = (tick_cnt_q == TW'(DIV - 1));
  assign maj       = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
  assign decide    = tick && (idx_q == 4'd9);
  assign stop_ferr = ferr_q | ~maj;
  assign exp_par   = (PARITY == 2) ? ^shift_q : ~^shift_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    idx_d      = idx_q;
    bit_cnt_d  = bit_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    push_d     = 1'b0;
    break_d    = 1'b0;
    if (tick) begin
      idx_d = idx_q + 4'd1;
      if (idx_q == 4'd7) s7_d = rx_s;
      if (idx_q == 4'd8) s8_d = rx_s;
    end
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          idx_d      = '0;
          bit_cnt_d  = '0;
          par_bit_d  = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      S_START: begin
        if (decide) state_d = maj ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_bit_d = maj;
          perr_d    = (maj != exp_par);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          ferr_d = stop_ferr;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            hi_cnt_d = '0;
            // An all-zero frame with a bad stop is a held-low line, not data.
            if (shift_q == '0 && !par_bit_q && stop_ferr) begin
              break_d = 1'b1;
              state_d = S_WAIT_HIGH;
            end else begin
              push_d  = 1'b1;
              state_d = maj ? S_IDLE : S_WAIT_HIGH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (tick) begin
          if (!rx_s) begin
            hi_cnt_d = '0;
          end else if (hi_cnt_q == 4'd15) begin
            state_d = S_IDLE;
          end else begin
            hi_cnt_d = hi_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      idx_q      <= '0;
      bit_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      s7_q       <= 1'b0;
      s8_q       <= 1'b0;
      push_q     <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], serial_rx};
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      bit_cnt_q  <= bit_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      push_q     <= push_d;
      break_q    <= break_d;
    end
  end

  // Receive FIFO: head entry is read combinationally (first-word-fall-through).
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overrun_q;
  logic          full, not_empty, pop, wr_en;
  logic [EW-1:0] head;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && rx_ready;
  assign wr_en     = push_q && (!full || pop);
  assign head      = mem[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= {shift_q, perr_q, ferr_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q   <= count_q + CW'(wr_en) - CW'(pop);
      overrun_q <= push_q && full && !pop;
    end
  end

  assign rx_valid   = not_empty;
  assign rx_data    = not_empty ? head[EW-1:2] : '0;
  assign parity_err = not_empty ? head[1] : 1'b0;
  assign frame_err  = not_empty ? head[0] : 1'b0;
  assign overrun    = overrun_q;
  assign break_det  = break_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: one no-parity and one even-parity receiver, frames driven
// bit by bit, popped entries compared against a scoreboard queue.
module tb_uart_rx_os;
  localparam int BITCLK = 64;  // DIV = 4 for 64 MHz / 1 Mbaud, 16 ticks per bit

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line_n = 1'b1, line_e = 1'b1;
  logic rdy_n = 1'b0, rdy_e = 1'b0;
  logic vld_n, vld_e, perr_n, perr_e, ferr_n, ferr_e;
  logic ovr_n, ovr_e, brk_n, brk_e;
  logic [7:0] data_n, data_e;
  logic [2:0] cnt_n, cnt_e;

  int checks = 0;
  int failures = 0;
  int ovr_cnt_n = 0, brk_cnt_n = 0, brk_cnt_e = 0, ovr_cnt_e = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;
  exp_t q_n[$];
  exp_t q_e[$];

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       sbit;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_HZ(64000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .clock(clk), .reset_n(rst_n), .serial_rx(line_n), .rx_valid(vld_n),
    .rx_ready(rdy_n), .rx_data(data_n), .parity_err(perr_n), .frame_err(ferr_n),
    .overrun(ovr_n), .break_det(brk_n), .fifo_count(cnt_n));

  uart_rx_os #(.CLK_HZ(64000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(2),
               .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .clock(clk), .reset_n(rst_n), .serial_rx(line_e), .rx_valid(vld_e),
    .rx_ready(rdy_e), .rx_data(data_e), .parity_err(perr_e), .frame_err(ferr_e),
    .overrun(ovr_e), .break_det(brk_e), .fifo_count(cnt_e));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (ovr_n) ovr_cnt_n++;
    if (brk_n) brk_cnt_n++;
    if (ovr_e) ovr_cnt_e++;
    if (brk_e) brk_cnt_e++;
  end

  always @(negedge clk) begin : mon_n
    exp_t e;
    if (rst_n && vld_n && rdy_n) begin
      checks++;
      if (q_n.size() == 0) begin
        failures++;
        $display("FAIL n_pop unexpected frame actual=0x%0h required=none", data_n);
      end else begin
        e = q_n.pop_front();
        if ({data_n, perr_n, ferr_n} !== {e.data, e.perr, e.ferr}) begin
          failures++;
          $display("FAIL n_pop actual=%h/%b/%b required=%h/%b/%b",
                   data_n, perr_n, ferr_n, e.data, e.perr, e.ferr);
        end else begin
          $display("ok   n_pop data=%h perr=%b ferr=%b", data_n, perr_n, ferr_n);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_e
    exp_t e;
    if (rst_n && vld_e && rdy_e) begin
      checks++;
      if (q_e.size() == 0) begin
        failures++;
        $display("FAIL e_pop unexpected frame actual=0x%0h required=none", data_e);
      end else begin
        e = q_e.pop_front();
        if ({data_e, perr_e, ferr_e} !== {e.data, e.perr, e.ferr}) begin
          failures++;
          $display("FAIL e_pop actual=%h/%b/%b required=%h/%b/%b",
                   data_e, perr_e, ferr_e, e.data, e.perr, e.ferr);
        end else begin
          $display("ok   e_pop data=%h perr=%b ferr=%b", data_e, perr_e, ferr_e);
        end
      end
    end
  end

  task automatic drive_bit(input int which, input logic v);
    if (which == 0) line_n = v;
    else line_e = v;
    repeat (BITCLK) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int bits);
    repeat (bits * BITCLK) @(posedge clk);
    #1;
  endtask

  // Start, 8 data bits LSB first, parity bit on the even-parity line, stop, 2 idle bits.
  task automatic send(input int which, input logic [7:0] d, input logic pbit,
                      input logic sbit);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (which == 1) drive_bit(which, pbit);
    drive_bit(which, sbit);
    if (which == 0) line_n = 1'b1;
    else line_e = 1'b1;
    idle(2);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int lat, b0, o0;
    logic [7:0] d;
    vecs[0] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    repeat (4) @(posedge clk);
    #1;
    check("rst_valid", int'(vld_n), 0);
    check("rst_count", int'(cnt_n), 0);
    check("rst_data", int'(data_n), 0);
    check("rst_flags", int'({perr_n, ferr_n, ovr_n, brk_n}), 0);
    rst_n = 1'b1;
    idle(1);

    // Even-parity receiver: table of frames, each popped and compared on arrival.
    rdy_e = 1'b1;
    foreach (vecs[i]) begin
      b0 = brk_cnt_e;
      if (!vecs[i].exp_brk)
        q_e.push_back('{vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr});
      send(1, vecs[i].data, vecs[i].pbit, vecs[i].sbit);
      check($sformatf("e_vec%0d_brk", i), brk_cnt_e - b0, int'(vecs[i].exp_brk));
    end
    check("e_drained", q_e.size(), 0);
    check("e_overrun", ovr_cnt_e, 0);

    // Latency: rx_valid must follow the stop-bit decision (clock 43 of the stop bit).
    rdy_n = 1'b0;
    q_n.push_back('{8'h5A, 1'b0, 1'b0});
    drive_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(0, d_bit(8'h5A, i));
    line_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= BITCLK; i++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && vld_n) lat = i;
    end
    check("n_latency_ok", int'(lat == 44 || lat == 45), 1);
    check("n_5a_data", int'(data_n), 'h5A);
    check("n_5a_flags", int'({perr_n, ferr_n}), 0);
    check("n_5a_count", int'(cnt_n), 1);
    rdy_n = 1'b1;
    idle(1);
    check("n_5a_popped", int'(cnt_n), 0);

    // False start: 5 ticks low, then high.
    line_n = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    line_n = 1'b1;
    idle(3);
    check("fs_count", int'(cnt_n), 0);
    check("fs_pending", q_n.size(), 0);
    q_n.push_back('{8'hA5, 1'b0, 1'b0});
    send(0, 8'hA5, 1'b0, 1'b1);
    check("fs_a5_drained", q_n.size(), 0);

    // Overrun: fill a 4-deep FIFO with no consumer, fifth frame dropped.
    rdy_n = 1'b0;
    o0 = ovr_cnt_n;
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k);
      if (k <= 4) q_n.push_back('{d, 1'b0, 1'b0});
      send(0, d, 1'b0, 1'b1);
    end
    check("ovr_count", int'(cnt_n), 4);
    check("ovr_pulses", ovr_cnt_n - o0, 1);
    check("ovr_head", int'(data_n), 1);
    rdy_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("ovr_drained", q_n.size(), 0);
    check("ovr_empty", int'(cnt_n), 0);

    // Break: line low for two frame times.
    b0 = brk_cnt_n;
    o0 = ovr_cnt_n;
    line_n = 1'b0;
    idle(20);
    line_n = 1'b1;
    idle(2);
    check("brk_pulses", brk_cnt_n - b0, 1);
    check("brk_count", int'(cnt_n), 0);
    check("brk_no_ovr", ovr_cnt_n - o0, 0);
    q_n.push_back('{8'h3C, 1'b0, 1'b0});
    send(0, 8'h3C, 1'b0, 1'b1);
    check("brk_3c_drained", q_n.size(), 0);

    // Reset in the middle of data bit 4.
    rdy_n = 1'b0;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d_bit(8'hC3, i));
    line_n = 1'b0;
    repeat (BITCLK / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    line_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_outputs", int'({vld_n, cnt_n, data_n, perr_n, ferr_n, ovr_n, brk_n}), 0);
    rst_n = 1'b1;
    idle(3);
    check("mid_rst_nopush", int'(cnt_n), 0);
    rdy_n = 1'b1;
    q_n.push_back('{8'hC3, 1'b0, 1'b0});
    send(0, 8'hC3, 1'b0, 1'b1);
    check("c3_drained", q_n.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic d_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
